// File: rtl/ecc_pkg.sv
// Shared types and helpers for the GF(2^M) elliptic-curve point unit:
// FSM state enum, default reduction polynomials, mode encodings, squarer.
package ecc_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_INV,
    S_SLOPE,
    S_XY
  } state_t;

  localparam logic [6:0] POLY_M7 = 7'h03;
  localparam logic [7:0] POLY_M8 = 8'h1B;

  localparam logic MODE_DBL = 1'b0;
  localparam logic MODE_ADD = 1'b1;

  // Widest field the squarer supports.
  localparam int SQ_W = 64;

  // Square = spread bits to even positions, then fold the top M-1 bits
  // back down with the reduction polynomial (x^M implicit).
  function automatic logic [SQ_W-1:0] gf_sq(
    input logic [SQ_W-1:0] a,
    input int              m,
    input logic [SQ_W-1:0] poly
  );
    logic [2*SQ_W-1:0] w;
    w = '0;
    for (int i = 0; i < m; i++) w[2*i] = a[i];
    for (int k = 2*m-2; k >= m; k--) begin
      if (w[k]) begin
        w[k] = 1'b0;
        for (int j = 0; j < m; j++) w[k-m+j] = w[k-m+j] ^ poly[j];
      end
    end
    return w[SQ_W-1:0];
  endfunction

endpackage

// File: rtl/ec_point_unit_gf_mul.sv
// Combinational GF(2^M) multiplier, polynomial basis, reduced mod POLY.
// Ports: a, b (M-bit operands) -> p (M-bit product).
module gf_mul
  import ecc_pkg::*;
#(
  parameter int          M    = 7,
  parameter logic [M-1:0] POLY = POLY_M7
) (
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic [M-1:0] p
);

  logic [M-1:0] acc;
  logic [M-1:0] sh;

  // sh walks a*x^i mod POLY; acc gathers the terms selected by b.
  always_comb begin
    acc = '0;
    sh  = a;
    for (int i = 0; i < M; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[M-2:0], 1'b0} ^ (sh[M-1] ? POLY : '0);
    end
    p = acc;
  end

endmodule

// File: rtl/ec_point_unit.sv
// Sequential EC point double / add over GF(2^M), fixed M-cycle latency.
// Ports: clk, rst (async high), start, mode, p_x/p_y, q_x/q_y in;
// ready, done, r_x/r_y out. Under ECPU_INF_EN: p_inf, q_inf in, r_inf out.
module ec_point_unit
  import ecc_pkg::*;
#(
  parameter int           M       = 7,
  parameter logic [M-1:0] POLY    = POLY_M7,
  parameter logic [M-1:0] CURVE_A = M'(1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         mode,
  input  logic [M-1:0] p_x,
  input  logic [M-1:0] p_y,
  input  logic [M-1:0] q_x,
  input  logic [M-1:0] q_y,
  output logic         ready,
  output logic         done,
  output logic [M-1:0] r_x,
  output logic [M-1:0] r_y
`ifdef ECPU_INF_EN
  ,
  input  logic         p_inf,
  input  logic         q_inf,
  output logic         r_inf
`endif
);

  localparam int CW = $clog2(M + 1);
  localparam logic [SQ_W-1:0] POLY_W = SQ_W'(POLY);

  state_t       st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [M-1:0] t_q, t_d, den_q, den_d, num_q, num_d, lam_q, lam_d;
  logic [M-1:0] px_q, px_d, py_q, py_d, qx_q, qx_d, qy_q, qy_d;
  logic [M-1:0] rx_q, rx_d, ry_q, ry_d;
  logic         dbl_q, dbl_d, done_q, done_d, ready_q, ready_d;
`ifdef ECPU_INF_EN
  logic         add_q, add_d, pinf_q, pinf_d, qinf_q, qinf_d;
  logic         rinf_q, rinf_d;
  logic         same;
`endif

  logic [M-1:0]    sq_in, sq_o, x3, mul_a, mul_b, prod;
  logic [SQ_W-1:0] sq_w;
  logic            dbl_in;

  gf_mul #(.M(M), .POLY(POLY)) u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (prod)
  );

  // One squarer: t in INV/SLOPE, lambda in XY.
  assign sq_in = (st_q == S_XY) ? lam_q : t_q;
  assign sq_w  = gf_sq(SQ_W'(sq_in), M, POLY_W);
  assign sq_o  = sq_w[M-1:0];
  assign x3    = sq_o ^ lam_q ^ CURVE_A ^ (dbl_q ? '0 : (px_q ^ qx_q));

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    t_d     = t_q;
    den_d   = den_q;
    num_d   = num_q;
    lam_d   = lam_q;
    px_d    = px_q;
    py_d    = py_q;
    qx_d    = qx_q;
    qy_d    = qy_q;
    rx_d    = rx_q;
    ry_d    = ry_q;
    dbl_d   = dbl_q;
    done_d  = 1'b0;
    ready_d = ready_q;
    mul_a   = sq_o;
    mul_b   = den_q;
    dbl_in  = (mode == MODE_DBL);
`ifdef ECPU_INF_EN
    add_d   = add_q;
    pinf_d  = pinf_q;
    qinf_d  = qinf_q;
    rinf_d  = rinf_q;
    // P == Q in add mode is routed through the doubling path.
    same    = (p_x == q_x) && (p_y == q_y);
    dbl_in  = (mode == MODE_DBL) || same;
`endif
    unique case (st_q)
      S_IDLE: begin
        if (start) begin
          px_d    = p_x;
          py_d    = p_y;
          qx_d    = q_x;
          qy_d    = q_y;
          dbl_d   = dbl_in;
          den_d   = dbl_in ? p_x : (p_x ^ q_x);
          num_d   = dbl_in ? p_y : (p_y ^ q_y);
          t_d     = dbl_in ? p_x : (p_x ^ q_x);
          cnt_d   = '0;
          ready_d = 1'b0;
          st_d    = S_INV;
`ifdef ECPU_INF_EN
          add_d   = (mode == MODE_ADD);
          pinf_d  = p_inf;
          qinf_d  = q_inf;
`endif
        end
      end
      S_INV: begin
        t_d   = prod;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(M - 3)) st_d = S_SLOPE;
      end
      S_SLOPE: begin
        // sq_o is den^-1 here; num already holds p_y for a double.
        mul_b = num_q;
        lam_d = prod ^ (dbl_q ? px_q : '0);
        st_d  = S_XY;
      end
      S_XY: begin
        mul_a   = lam_q;
        mul_b   = px_q ^ x3;
        rx_d    = x3;
        ry_d    = prod ^ x3 ^ py_q;
`ifdef ECPU_INF_EN
        rinf_d  = 1'b0;
        if (pinf_q) begin
          rx_d   = add_q ? qx_q : '0;
          ry_d   = add_q ? qy_q : '0;
          rinf_d = add_q ? qinf_q : 1'b1;
        end else if (add_q && qinf_q) begin
          rx_d = px_q;
          ry_d = py_q;
        end else if ((!dbl_q && px_q == qx_q) ||
                     (dbl_q && px_q == '0)) begin
          rx_d   = '0;
          ry_d   = '0;
          rinf_d = 1'b1;
        end
`endif
        done_d  = 1'b1;
        ready_d = 1'b1;
        st_d    = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= S_IDLE;
      cnt_q   <= '0;
      t_q     <= '0;
      den_q   <= '0;
      num_q   <= '0;
      lam_q   <= '0;
      px_q    <= '0;
      py_q    <= '0;
      qx_q    <= '0;
      qy_q    <= '0;
      rx_q    <= '0;
      ry_q    <= '0;
      dbl_q   <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
`ifdef ECPU_INF_EN
      add_q   <= 1'b0;
      pinf_q  <= 1'b0;
      qinf_q  <= 1'b0;
      rinf_q  <= 1'b0;
`endif
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      t_q     <= t_d;
      den_q   <= den_d;
      num_q   <= num_d;
      lam_q   <= lam_d;
      px_q    <= px_d;
      py_q    <= py_d;
      qx_q    <= qx_d;
      qy_q    <= qy_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
      dbl_q   <= dbl_d;
      done_q  <= done_d;
      ready_q <= ready_d;
`ifdef ECPU_INF_EN
      add_q   <= add_d;
      pinf_q  <= pinf_d;
      qinf_q  <= qinf_d;
      rinf_q  <= rinf_d;
`endif
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign r_x   = rx_q;
  assign r_y   = ry_q;
`ifdef ECPU_INF_EN
  assign r_inf = rinf_q;
`endif

endmodule

// File: tb/tb_ec_point_unit.sv
// Directed bench for ec_point_unit: M=7 default instance and M=8/0x1B.
// Build with +define+ECPU_INF_EN to also cover the infinity handling.
module tb_ec_point_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start7 = 1'b0;
  logic       start8 = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] px = '0, py = '0, qx = '0, qy = '0;
  logic       ready7, done7, ready8, done8;
  logic [6:0] rx7, ry7;
  logic [7:0] rx8, ry8;
`ifdef ECPU_INF_EN
  logic       pinf = 1'b0, qinf = 1'b0;
  logic       rinf7, rinf8;
`endif

  int vec = 0;
  int err = 0;

  always #5 clk = ~clk;

  ec_point_unit u7 (
    .clk(clk), .rst(rst), .start(start7), .mode(mode),
    .p_x(px[6:0]), .p_y(py[6:0]), .q_x(qx[6:0]), .q_y(qy[6:0]),
    .ready(ready7), .done(done7), .r_x(rx7), .r_y(ry7)
`ifdef ECPU_INF_EN
    , .p_inf(pinf), .q_inf(qinf), .r_inf(rinf7)
`endif
  );

  ec_point_unit #(.M(8), .POLY(8'h1B), .CURVE_A(8'h01)) u8 (
    .clk(clk), .rst(rst), .start(start8), .mode(mode),
    .p_x(px), .p_y(py), .q_x(qx), .q_y(qy),
    .ready(ready8), .done(done8), .r_x(rx8), .r_y(ry8)
`ifdef ECPU_INF_EN
    , .p_inf(pinf), .q_inf(qinf), .r_inf(rinf8)
`endif
  );

  // Software GF(2^m) model, m <= 8.
  function automatic logic [7:0] mmul(input logic [7:0] a, input logic [7:0] b,
                                      input int m, input logic [7:0] poly);
    logic [15:0] w;
    w = '0;
    for (int i = 0; i < m; i++) if (b[i]) w = w ^ (16'(a) << i);
    for (int k = 2*m-2; k >= m; k--)
      if (w[k]) begin
        w[k] = 1'b0;
        w = w ^ (16'(poly) << (k - m));
      end
    return w[7:0];
  endfunction

  function automatic logic [7:0] minv(input logic [7:0] a, input int m,
                                      input logic [7:0] poly);
    for (int y = 1; y < (1 << m); y++)
      if (mmul(a, 8'(y), m, poly) == 8'h01) return 8'(y);
    return 8'h00;
  endfunction

  task automatic model(input int m, input logic [7:0] poly, input logic md,
                       input logic [7:0] ax, input logic [7:0] ay,
                       input logic [7:0] bx, input logic [7:0] by,
                       output logic [7:0] ex, output logic [7:0] ey);
    logic [7:0] inv, lam;
    if (md == 1'b0) begin
      inv = minv(ax, m, poly);
      lam = ax ^ mmul(inv, ay, m, poly);
      ex  = mmul(lam, lam, m, poly) ^ lam ^ 8'h01;
    end else begin
      inv = minv(ax ^ bx, m, poly);
      lam = mmul(inv, ay ^ by, m, poly);
      ex  = mmul(lam, lam, m, poly) ^ lam ^ ax ^ bx ^ 8'h01;
    end
    ey = mmul(lam, ax ^ ex, m, poly) ^ ex ^ ay;
  endtask

  // Issue one operation and watch 20 cycles for done pulses.
  task automatic run(input int w, input logic md,
                     input logic [7:0] ax, input logic [7:0] ay,
                     input logic [7:0] bx, input logic [7:0] by,
                     output int lat, output int nd,
                     output logic [7:0] ox, output logic [7:0] oy,
                     output logic rdy_after, output logic rdy_done);
    logic d;
    lat = 0; nd = 0; ox = '0; oy = '0; rdy_done = 1'b0;
    @(posedge clk); #1;
    mode = md; px = ax; py = ay; qx = bx; qy = by;
    if (w == 8) start8 = 1'b1; else start7 = 1'b1;
    @(posedge clk); #1;
    start7 = 1'b0; start8 = 1'b0;
    rdy_after = (w == 8) ? ready8 : ready7;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      d = (w == 8) ? done8 : done7;
      if (d) begin
        nd++;
        if (nd == 1) begin
          lat = i;
          ox = (w == 8) ? rx8 : {1'b0, rx7};
          oy = (w == 8) ? ry8 : {1'b0, ry7};
          rdy_done = (w == 8) ? ready8 : ready7;
        end
      end
    end
  endtask

  task automatic test_reset;
    vec++; if (ready7 !== 1'b1) begin err++; $display("FAIL reset_ready got %b want 1", ready7); end
    vec++; if (done7 !== 1'b0) begin err++; $display("FAIL reset_done got %b want 0", done7); end
    vec++; if ({rx7, ry7} !== 14'h0) begin err++; $display("FAIL reset_r got %h/%h want 0/0", rx7, ry7); end
    vec++; if (ready8 !== 1'b1 || {rx8, ry8} !== 16'h0) begin
      err++; $display("FAIL reset_m8 got rdy=%b r=%h/%h want 1 0/0", ready8, rx8, ry8);
    end
`ifdef ECPU_INF_EN
    vec++; if (rinf7 !== 1'b0) begin err++; $display("FAIL reset_rinf got %b want 0", rinf7); end
`endif
  endtask

  task automatic test_double_m7;
    int lat, nd; logic [7:0] ox, oy; logic ra, rd;
    run(7, 1'b0, 8'd1, 8'd0, 8'd0, 8'd0, lat, nd, ox, oy, ra, rd);
    vec++; if (ox !== 8'd1 || oy !== 8'd1) begin err++; $display("FAIL dbl7_r got %h/%h want 01/01", ox, oy); end
    vec++; if (lat !== 7) begin err++; $display("FAIL dbl7_latency got %0d want 7", lat); end
    vec++; if (nd !== 1) begin err++; $display("FAIL dbl7_pulses got %0d want 1", nd); end
    vec++; if (ra !== 1'b0) begin err++; $display("FAIL dbl7_ready_fall got %b want 0", ra); end
    vec++; if (rd !== 1'b1) begin err++; $display("FAIL dbl7_ready_rise got %b want 1", rd); end
  endtask

  task automatic test_add_degenerate;
    int lat, nd; logic [7:0] ox, oy; logic ra, rd;
    run(7, 1'b1, 8'd1, 8'd0, 8'd1, 8'd1, lat, nd, ox, oy, ra, rd);
`ifdef ECPU_INF_EN
    vec++; if (rinf7 !== 1'b1 || ox !== 8'd0 || oy !== 8'd0) begin
      err++; $display("FAIL add_opp got inf=%b r=%h/%h want 1 00/00", rinf7, ox, oy);
    end
`else
    vec++; if (ox !== 8'd1 || oy !== 8'd1) begin err++; $display("FAIL add_opp got %h/%h want 01/01", ox, oy); end
`endif
    vec++; if (lat !== 7) begin err++; $display("FAIL add_opp_latency got %0d want 7", lat); end
  endtask

`ifdef ECPU_INF_EN
  task automatic test_inf;
    int lat, nd; logic [7:0] ox, oy; logic ra, rd;
    qinf = 1'b1;
    run(7, 1'b1, 8'h05, 8'h03, 8'h09, 8'h02, lat, nd, ox, oy, ra, rd);
    qinf = 1'b0;
    vec++; if (ox !== 8'h05 || oy !== 8'h03 || rinf7 !== 1'b0 || lat !== 7) begin
      err++; $display("FAIL inf_qinf got %h/%h inf=%b lat=%0d want 05/03 0 7", ox, oy, rinf7, lat);
    end
    pinf = 1'b1;
    run(7, 1'b1, 8'h05, 8'h03, 8'h09, 8'h02, lat, nd, ox, oy, ra, rd);
    vec++; if (ox !== 8'h09 || oy !== 8'h02 || rinf7 !== 1'b0) begin
      err++; $display("FAIL inf_pinf_add got %h/%h inf=%b want 09/02 0", ox, oy, rinf7);
    end
    run(7, 1'b0, 8'h05, 8'h03, 8'h00, 8'h00, lat, nd, ox, oy, ra, rd);
    pinf = 1'b0;
    vec++; if (rinf7 !== 1'b1 || ox !== 8'h00 || oy !== 8'h00) begin
      err++; $display("FAIL inf_pinf_dbl got inf=%b r=%h/%h want 1 00/00", rinf7, ox, oy);
    end
    run(7, 1'b1, 8'd1, 8'd0, 8'd1, 8'd0, lat, nd, ox, oy, ra, rd);
    vec++; if (ox !== 8'd1 || oy !== 8'd1 || rinf7 !== 1'b0 || lat !== 7) begin
      err++; $display("FAIL inf_same got %h/%h inf=%b lat=%0d want 01/01 0 7", ox, oy, rinf7, lat);
    end
    run(7, 1'b0, 8'd0, 8'd5, 8'd0, 8'd0, lat, nd, ox, oy, ra, rd);
    vec++; if (rinf7 !== 1'b1 || ox !== 8'd0 || oy !== 8'd0 || lat !== 7) begin
      err++; $display("FAIL inf_dbl_x0 got inf=%b r=%h/%h lat=%0d want 1 00/00 7", rinf7, ox, oy, lat);
    end
  endtask
`endif

  task automatic test_model(input int w);
    int lat, nd; logic [7:0] ox, oy, ex, ey, ax, ay, bx, by, pl, msk; logic ra, rd;
    int m;
    m   = w;
    pl  = (w == 8) ? 8'h1B : 8'h03;
    msk = (w == 8) ? 8'hFF : 8'h7F;
    for (int k = 0; k < 6; k++) begin
      ax = 8'($urandom_range(1, 255)) & msk;
      if (ax == 8'h00) ax = 8'h01;
      ay = 8'($urandom_range(0, 255)) & msk;
      bx = 8'($urandom_range(0, 255)) & msk;
      if (bx == ax) bx = ax ^ 8'h01;
      by = 8'($urandom_range(0, 255)) & msk;
      model(m, pl, k[0], ax, ay, bx, by, ex, ey);
      run(w, k[0], ax, ay, bx, by, lat, nd, ox, oy, ra, rd);
      vec++; if (ox !== ex || oy !== ey || lat !== m) begin
        err++;
        $display("FAIL model_m%0d_%0d got %h/%h lat=%0d want %h/%h lat=%0d", m, k, ox, oy, lat, ex, ey, m);
      end
    end
  endtask

  task automatic test_m8_double;
    int lat, nd; logic [7:0] ox, oy; logic ra, rd;
    run(8, 1'b0, 8'd1, 8'd0, 8'd0, 8'd0, lat, nd, ox, oy, ra, rd);
    vec++; if (ox !== 8'd1 || oy !== 8'd1 || lat !== 8 || nd !== 1) begin
      err++; $display("FAIL dbl8 got %h/%h lat=%0d n=%0d want 01/01 8 1", ox, oy, lat, nd);
    end
  endtask

  task automatic test_back_to_back;
    int nd;
    logic [7:0] ox, oy;
    nd = 0; ox = '0; oy = '0;
    @(posedge clk); #1;
    mode = 1'b0; px = 8'd1; py = 8'd0; start7 = 1'b1;
    @(posedge clk); #1;
    start7 = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      @(posedge clk); #1;
      if (done7) begin nd++; if (nd == 1) begin ox = {1'b0, rx7}; oy = {1'b0, ry7}; end end
      // Requests land at edges 2, 4 and 7 (the edge that raises done).
      start7 = (i == 1 || i == 3 || i == 6);
      if (start7) begin px = 8'h05; py = 8'h03; end
    end
    start7 = 1'b0;
    vec++; if (nd !== 1) begin err++; $display("FAIL busy_dones got %0d want 1", nd); end
    vec++; if (ox !== 8'd1 || oy !== 8'd1) begin err++; $display("FAIL busy_r got %h/%h want 01/01", ox, oy); end
  endtask

  task automatic test_reset_mid;
    int nd, lat, nd2; logic [7:0] ox, oy; logic ra, rd;
    nd = 0;
    @(posedge clk); #1;
    mode = 1'b0; px = 8'h05; py = 8'h03; start7 = 1'b1;
    @(posedge clk); #1;
    start7 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    vec++; if (ready7 !== 1'b1 || done7 !== 1'b0) begin
      err++; $display("FAIL rstmid_ctl got rdy=%b done=%b want 1 0", ready7, done7);
    end
    vec++; if ({rx7, ry7} !== 14'h0) begin err++; $display("FAIL rstmid_r got %h/%h want 0/0", rx7, ry7); end
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 12; i++) begin @(posedge clk); #1; if (done7) nd++; end
    vec++; if (nd !== 0) begin err++; $display("FAIL rstmid_done got %0d want 0", nd); end
    run(7, 1'b0, 8'd1, 8'd0, 8'd0, 8'd0, lat, nd2, ox, oy, ra, rd);
    vec++; if (ox !== 8'd1 || oy !== 8'd1 || lat !== 7) begin
      err++; $display("FAIL rstmid_after got %h/%h lat=%0d want 01/01 7", ox, oy, lat);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    rst = 1'b0;
    test_double_m7;
    test_add_degenerate;
`ifdef ECPU_INF_EN
    test_inf;
`endif
    test_model(7);
    test_m8_double;
    test_model(8);
    test_back_to_back;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
